// File: rtl/sd_image_pkg.sv
// Shared types for the SD image loader: pixel formats, FSM states and format helpers.
package sd_image_pkg;

    typedef enum logic [1:0] {
        FMT_RGB888 = 2'd0,
        FMT_RGB565 = 2'd1,
        FMT_GRAY8  = 2'd2,
        FMT_RSVD   = 2'd3
    } pix_fmt_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StRecv   = 2'd2,
        StFinish = 2'd3
    } load_state_e;

    function automatic logic [1:0] bytes_per_pixel(input pix_fmt_e fmt);
        logic [1:0] n;
        case (fmt)
            FMT_RGB888: n = 2'd3;
            FMT_RGB565: n = 2'd2;
            default:    n = 2'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sd_image_loader_if.sv
// Byte-stream and block-request handshake between the loader and the SD controller.
interface sd_image_loader_if;
    logic [7:0]  sd_data_in;
    logic        sd_data_valid;
    logic        sd_ready;
    logic        sd_read_block;
    logic [31:0] sd_block_addr;

    modport master (
        input  sd_data_in,
        input  sd_data_valid,
        input  sd_ready,
        output sd_read_block,
        output sd_block_addr
    );

    modport slave (
        output sd_data_in,
        output sd_data_valid,
        output sd_ready,
        input  sd_read_block,
        input  sd_block_addr
    );
endinterface

// File: rtl/pixel_unpacker.sv
// Assembles 1..3 byte pixels from a byte stream and decodes them to 3*CH_BITS RGB.
module pixel_unpacker
    import sd_image_pkg::*;
#(
    parameter int unsigned CH_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   valid_i,
    input  pix_fmt_e               fmt_i,
    input  logic [7:0]             byte_i,
    output logic                   pix_valid_o,
    output logic [3*CH_BITS-1:0]   pixel_o
);

    logic [1:0] phase_q, phase_d;
    logic [7:0] byte0_q, byte0_d;
    logic [7:0] byte1_q, byte1_d;
    logic       last_byte;

    // Shift-based truncation keeps every source bit referenced for any CH_BITS.
    function automatic logic [CH_BITS-1:0] top8(input logic [7:0] v);
        return CH_BITS'(v >> (8 - CH_BITS));
    endfunction

    function automatic logic [CH_BITS-1:0] top6(input logic [5:0] v);
        return CH_BITS'(v >> (6 - CH_BITS));
    endfunction

    function automatic logic [CH_BITS-1:0] top5(input logic [4:0] v);
        return CH_BITS'(v >> (5 - CH_BITS));
    endfunction

    assign last_byte   = (phase_q == (bytes_per_pixel(fmt_i) - 2'd1));
    assign pix_valid_o = valid_i & last_byte;

    always_comb begin
        phase_d = phase_q;
        byte0_d = byte0_q;
        byte1_d = byte1_q;
        if (start_i) begin
            phase_d = 2'd0;
        end else if (valid_i) begin
            phase_d = last_byte ? 2'd0 : phase_q + 2'd1;
            if (phase_q == 2'd0) byte0_d = byte_i;
            if (phase_q == 2'd1) byte1_d = byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 2'd0;
            byte0_q <= 8'd0;
            byte1_q <= 8'd0;
        end else begin
            phase_q <= phase_d;
            byte0_q <= byte0_d;
            byte1_q <= byte1_d;
        end
    end

    // The final byte of a pixel is decoded straight from byte_i so the write lands this cycle.
    always_comb begin
        logic [CH_BITS-1:0] r, g, b;
        r = top8(byte0_q);
        g = top8(byte1_q);
        b = top8(byte_i);
        case (fmt_i)
            FMT_RGB565: begin
                r = top5(byte_i[7:3]);
                g = top6({byte_i[2:0], byte0_q[7:5]});
                b = top5(byte0_q[4:0]);
            end
            FMT_GRAY8: begin
                r = top8(byte_i);
                g = r;
                b = r;
            end
            default: ;
        endcase
        pixel_o = {r, g, b};
    end

endmodule

// File: rtl/sd_image_loader.sv
// Streams one image from SD blocks into an inline framebuffer with a registered scanout port.
module sd_image_loader
    import sd_image_pkg::*;
#(
    parameter int unsigned IMG_W        = 320,
    parameter int unsigned IMG_H        = 240,
    parameter int unsigned CH_BITS      = 4,
    parameter int unsigned BLOCK_BYTES  = 512,
    parameter int unsigned NUM_IMAGES   = 4,
    parameter logic [31:0] BASE_BLOCK   = 32'h0000_0000,
    parameter logic [31:0] IMAGE_STRIDE = 32'h0001_0000,
    parameter int unsigned FB_AW        = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    sd_image_loader_if.master     sd,
    input  logic                  load_start,
    input  logic [3:0]            image_select,
    input  logic [1:0]            pix_fmt,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_ready,
    output logic                  load_error,
    input  logic [FB_AW-1:0]      addrb,
    output logic [3*CH_BITS-1:0]  dataOut
);

    localparam int unsigned TOTAL = IMG_W * IMG_H;
    localparam int unsigned BCW   = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned PW    = 3 * CH_BITS;

    load_state_e       state_q, state_d;
    pix_fmt_e          fmt_q, fmt_d;
    logic [31:0]       cur_block_q, cur_block_d;
    logic [31:0]       addr_q, addr_d;
    logic              read_q, read_d;
    logic [FB_AW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic              pix_done_q, pix_done_d;
    logic              frame_ready_q, frame_ready_d;
    logic              load_error_q, load_error_d;
    logic              accept;
    logic              feed;
    logic              pix_we;
    logic [PW-1:0]     pixel;
    logic [PW-1:0]     dout_q;

    // Once every pixel is written the remaining block bytes are drained without decoding.
    assign feed = (state_q == StRecv) & sd.sd_data_valid & ~pix_done_q;

    pixel_unpacker #(
        .CH_BITS (CH_BITS)
    ) u_unpacker (
        .clk         (clk),
        .reset       (reset),
        .start_i     (accept),
        .valid_i     (feed),
        .fmt_i       (fmt_q),
        .byte_i      (sd.sd_data_in),
        .pix_valid_o (pix_we),
        .pixel_o     (pixel)
    );

    always_comb begin
        state_d       = state_q;
        fmt_d         = fmt_q;
        cur_block_d   = cur_block_q;
        addr_d        = addr_q;
        read_d        = 1'b0;
        pix_cnt_d     = pix_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        pix_done_d    = pix_done_q;
        frame_ready_d = frame_ready_q;
        load_error_d  = load_error_q;
        accept        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    if ((32'(image_select) >= NUM_IMAGES) || (pix_fmt == 2'd3)) begin
                        load_error_d = 1'b1;
                    end else begin
                        accept        = 1'b1;
                        fmt_d         = pix_fmt_e'(pix_fmt);
                        cur_block_d   = BASE_BLOCK + 32'(image_select) * IMAGE_STRIDE;
                        pix_cnt_d     = '0;
                        byte_cnt_d    = '0;
                        pix_done_d    = 1'b0;
                        frame_ready_d = 1'b0;
                        load_error_d  = 1'b0;
                        state_d       = StReq;
                    end
                end
            end
            StReq: begin
                if (sd.sd_ready) begin
                    read_d  = 1'b1;
                    addr_d  = cur_block_q;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (sd.sd_data_valid) begin
                    if (pix_we) begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (pix_cnt_q == FB_AW'(TOTAL - 1)) pix_done_d = 1'b1;
                    end
                    if (byte_cnt_q == BCW'(BLOCK_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        if (pix_done_d) begin
                            frame_ready_d = 1'b1;
                            state_d       = StFinish;
                        end else begin
                            cur_block_d = cur_block_q + 32'd1;
                            state_d     = StReq;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            StFinish: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            fmt_q         <= FMT_RGB888;
            cur_block_q   <= '0;
            addr_q        <= '0;
            read_q        <= 1'b0;
            pix_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            pix_done_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            load_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fmt_q         <= fmt_d;
            cur_block_q   <= cur_block_d;
            addr_q        <= addr_d;
            read_q        <= read_d;
            pix_cnt_q     <= pix_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            pix_done_q    <= pix_done_d;
            frame_ready_q <= frame_ready_d;
            load_error_q  <= load_error_d;
        end
    end

    logic [PW-1:0] fb_mem [0:(1<<FB_AW)-1];

    always_ff @(posedge clk) begin
        if (pix_we) fb_mem[pix_cnt_q] <= pixel;
    end

    always_ff @(posedge clk) begin
        if (reset) dout_q <= '0;
        else       dout_q <= fb_mem[addrb];
    end

    assign sd.sd_read_block = read_q;
    assign sd.sd_block_addr = addr_q;
    assign busy             = (state_q == StReq) | (state_q == StRecv);
    assign done             = (state_q == StFinish);
    assign frame_ready      = frame_ready_q;
    assign load_error       = load_error_q;
    assign dataOut          = dout_q;

endmodule

// File: tb/tb_sd_image_loader.sv
// Randomised self-checking bench for sd_image_loader against a byte-stream pixel model.
module tb_sd_image_loader;
    import sd_image_pkg::*;

    localparam int unsigned CH   = 4;
    localparam int unsigned BB   = 16;
    localparam int unsigned NPIX = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [3:0]  image_select = 4'd0;
    logic [1:0]  pix_fmt = 2'd0;
    logic [2:0]  addrb = 3'd0;
    logic        busy, done, frame_ready, load_error;
    logic [11:0] dataOut;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    int done_cnt = 0;
    logic [7:0] stream[$];

    sd_image_loader_if sif ();

    sd_image_loader #(
        .IMG_W        (4),
        .IMG_H        (2),
        .CH_BITS      (CH),
        .BLOCK_BYTES  (BB),
        .NUM_IMAGES   (4),
        .BASE_BLOCK   (32'h0000_0000),
        .IMAGE_STRIDE (32'h0001_0000),
        .FB_AW        (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sd           (sif),
        .load_start   (load_start),
        .image_select (image_select),
        .pix_fmt      (pix_fmt),
        .busy         (busy),
        .done         (done),
        .frame_ready  (frame_ready),
        .load_error   (load_error),
        .addrb        (addrb),
        .dataOut      (dataOut)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sif.sd_read_block) pulse_cnt <= pulse_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int bpp(input int fmt);
        return (fmt == 0) ? 3 : (fmt == 1) ? 2 : 1;
    endfunction

    // Pixel i taken from the flat byte stream, independent of block boundaries.
    function automatic logic [11:0] model_pixel(input int fmt, input int i);
        int r, g, b, w;
        if (fmt == 0) begin
            r = int'(stream[3*i])   >> (8 - CH);
            g = int'(stream[3*i+1]) >> (8 - CH);
            b = int'(stream[3*i+2]) >> (8 - CH);
        end else if (fmt == 1) begin
            w = int'(stream[2*i]) + 256 * int'(stream[2*i+1]);
            r = ((w >> 11) & 31) >> (5 - CH);
            g = ((w >> 5) & 63) >> (6 - CH);
            b = (w & 31) >> (5 - CH);
        end else begin
            r = int'(stream[i]) >> (8 - CH);
            g = r;
            b = r;
        end
        return 12'((r << (2*CH)) | (g << CH) | b);
    endfunction

    task automatic fill_stream(input int fmt, input int mode);
        int nblk;
        nblk = (NPIX * bpp(fmt) + BB - 1) / BB;
        stream.delete();
        for (int i = 0; i < nblk * BB; i++) begin
            case (mode)
                1:       stream.push_back(8'(i));
                2:       stream.push_back((i % 2) ? 8'hF8 : 8'h1F);
                3:       stream.push_back(8'hA7);
                default: stream.push_back(8'($urandom));
            endcase
        end
    endtask

    task automatic run_load(input int img, input int fmt, input int ready_delay,
                            input int gap_pct, input bit poke);
        int nblk, base_p, base_d;
        logic [31:0] exp_base;
        logic [11:0] exp_pix;
        bit seen;
        nblk     = stream.size() / BB;
        exp_base = 32'(img) * 32'h0001_0000;
        base_p   = pulse_cnt;
        base_d   = done_cnt;
        if (ready_delay > 0) sif.sd_ready = 1'b0;
        image_select = 4'(img);
        pix_fmt      = 2'(fmt);
        load_start   = 1'b1;
        @(posedge clk); #1;
        load_start   = 1'b0;
        image_select = 4'($urandom);
        pix_fmt      = 2'($urandom);
        tests++;
        if (busy !== 1'b1 || load_error !== 1'b0) begin
            fails++;
            $display("FAIL accept img%0d: busy=%b load_error=%b, required busy=1 load_error=0",
                     img, busy, load_error);
        end
        if (ready_delay > 0) begin
            repeat (ready_delay) @(posedge clk);
            #1;
            tests++;
            if (pulse_cnt != base_p || sif.sd_read_block !== 1'b0) begin
                fails++;
                $display("FAIL ready_stall: %0d pulses while sd_ready low, required 0",
                         pulse_cnt - base_p);
            end
            sif.sd_ready = 1'b1;
        end
        for (int b = 0; b < nblk; b++) begin
            seen = 1'b0;
            for (int c = 0; c < 64; c++) begin
                if (sif.sd_read_block === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            tests++;
            if (!seen) begin
                fails++;
                $display("FAIL req_timeout block %0d: no sd_read_block, required a pulse", b);
            end
            tests++;
            if (sif.sd_block_addr !== exp_base + 32'(b)) begin
                fails++;
                $display("FAIL block_addr %0d: got %h, required %h", b, sif.sd_block_addr,
                         exp_base + 32'(b));
            end
            for (int k = 0; k < int'(BB); k++) begin
                while ($urandom_range(99) < gap_pct) begin
                    sif.sd_data_valid = 1'b0;
                    sif.sd_data_in    = 8'($urandom);
                    @(posedge clk); #1;
                end
                sif.sd_data_valid = 1'b1;
                sif.sd_data_in    = stream[b*BB + k];
                if (poke && b == 0 && k == 5) begin
                    load_start   = 1'b1;
                    image_select = 4'((img + 1) % 4);
                end
                @(posedge clk); #1;
                load_start = 1'b0;
            end
            sif.sd_data_valid = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL done_timeout img%0d: done never pulsed, required a pulse", img);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (pulse_cnt - base_p != nblk || done_cnt - base_d != 1) begin
            fails++;
            $display("FAIL pulse_counts: reads=%0d done=%0d, required reads=%0d done=1",
                     pulse_cnt - base_p, done_cnt - base_d, nblk);
        end
        tests++;
        if (frame_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL finish_flags: frame_ready=%b busy=%b, required 1 and 0",
                     frame_ready, busy);
        end
        for (int i = 0; i < int'(NPIX); i++) begin
            addrb = 3'(i);
            @(posedge clk); #1;
            exp_pix = model_pixel(fmt, i);
            tests++;
            if (dataOut !== exp_pix) begin
                fails++;
                $display("FAIL pixel fmt%0d[%0d]: got %h, required %h", fmt, i, dataOut, exp_pix);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, frame_ready, load_error, sif.sd_read_block} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: busy/done/frame_ready/load_error/read=%b, required 00000",
                     {busy, done, frame_ready, load_error, sif.sd_read_block});
        end
        tests++;
        if (sif.sd_block_addr !== 32'd0) begin
            fails++;
            $display("FAIL reset_addr: got %h, required 0", sif.sd_block_addr);
        end
        tests++;
        if (dataOut !== 12'd0) begin
            fails++;
            $display("FAIL reset_dataOut: got %h, required 0", dataOut);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rgb888();
        fill_stream(0, 1);
        run_load(1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_rgb565();
        fill_stream(1, 2);
        run_load(0, 1, 0, 20, 1'b0);
    endtask

    task automatic test_reject();
        int base_p;
        base_p       = pulse_cnt;
        image_select = 4'd4;
        pix_fmt      = 2'd0;
        load_start   = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        tests++;
        if (load_error !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reject_image: load_error=%b busy=%b, required 1 and 0",
                     load_error, busy);
        end
        image_select = 4'd0;
        pix_fmt      = 2'd3;
        load_start   = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (load_error !== 1'b1 || busy !== 1'b0 || pulse_cnt != base_p) begin
            fails++;
            $display("FAIL reject_fmt: load_error=%b busy=%b reads=%0d, required 1, 0, 0",
                     load_error, busy, pulse_cnt - base_p);
        end
    endtask

    task automatic test_gray8();
        fill_stream(2, 3);
        run_load(3, 2, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        bit seen;
        int f;
        fill_stream(0, 0);
        image_select = 4'd0;
        pix_fmt      = 2'd0;
        load_start   = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (sif.sd_read_block === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL midload_req: no sd_read_block, required a pulse");
        end
        repeat (5) begin
            sif.sd_data_valid = 1'b1;
            sif.sd_data_in    = 8'($urandom);
            @(posedge clk); #1;
        end
        sif.sd_data_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if ({busy, done, frame_ready, sif.sd_read_block} !== 4'b0) begin
            fails++;
            $display("FAIL midload_reset: busy/done/frame_ready/read=%b, required 0000",
                     {busy, done, frame_ready, sif.sd_read_block});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        f = int'($urandom_range(2));
        fill_stream(f, 0);
        run_load(2, f, 0, 30, 1'b0);
    endtask

    task automatic test_ready_stall();
        fill_stream(1, 0);
        run_load(3, 1, 10, 0, 1'b0);
    endtask

    task automatic test_random_loads();
        int f;
        for (int n = 0; n < 6; n++) begin
            f = int'($urandom_range(2));
            fill_stream(f, 0);
            run_load(int'($urandom_range(3)), f, int'($urandom_range(3)), 40, 1'b1);
        end
    endtask

    initial begin
        sif.sd_data_in    = 8'd0;
        sif.sd_data_valid = 1'b0;
        sif.sd_ready      = 1'b1;
        test_reset();
        test_rgb888();
        test_rgb565();
        test_reject();
        test_gray8();
        test_reset_mid_load();
        test_ready_stall();
        test_random_loads();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
